instruction_decode: RTL

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/register_file.sv | 35 +++
 rtl/instruction_decode.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS-style decode stage: instruction layout, opcodes
// and a per-opcode operand/class table.
package mips_pkg;

  localparam int ADDRESSWIDTH = 32;
  localparam int DATAWIDTH    = 32;

  typedef enum logic [5:0] {
    ADD  = 6'h00, ADDI = 6'h01, SUB  = 6'h02, SUBI = 6'h03,
    MUL  = 6'h04, MULI = 6'h05, OR   = 6'h06, ORI  = 6'h07,
    AND  = 6'h08, ANDI = 6'h09, XOR  = 6'h0A, XORI = 6'h0B,
    LDW  = 6'h0C, STW  = 6'h0D, BZ   = 6'h0E, BEQ  = 6'h0F,
    JR   = 6'h10, HALT = 6'h11
  } opcode_t;

  // rd shares bits [15:11] with imm16, so the low half is a union.
  typedef struct packed {
    logic [4:0]  rd;
    logic [10:0] funct;
  } rtype_t;

  typedef union packed {
    logic [15:0] imm16;
    rtype_t      r;
  } lowfield_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    lowfield_t  low;
  } Instruct;

  typedef struct packed {
    logic legal;
    logic reads_rs;
    logic reads_rt;
    logic has_dest;
    logic dest_is_rd;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
  } decode_t;

  function automatic decode_t decode_op(input logic [5:0] op);
    decode_t d;
    d = '0;
    case (op)
      ADD, SUB, MUL, OR, AND, XOR: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.reads_rt = 1'b1;
        d.has_dest = 1'b1; d.dest_is_rd = 1'b1;
      end
      ADDI, SUBI, MULI, ORI, ANDI, XORI: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.has_dest = 1'b1;
      end
      LDW: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.has_dest = 1'b1; d.is_load = 1'b1;
      end
      STW: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.reads_rt = 1'b1; d.is_store = 1'b1;
      end
      BZ, JR: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.is_branch = 1'b1;
      end
      BEQ: begin
        d.legal = 1'b1; d.reads_rs = 1'b1; d.reads_rt = 1'b1; d.is_branch = 1'b1;
      end
      HALT: begin
        d.legal = 1'b1; d.is_halt = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/register_file.sv
// REGCOUNT x DATAWIDTH register file: two combinational read ports with
// same-cycle writeback bypass, one write port, R0 hardwired to zero.
module register_file #(
  parameter int DATAWIDTH = 32,
  parameter int REGCOUNT  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           raddr_a,
  input  logic [4:0]           raddr_b,
  output logic [DATAWIDTH-1:0] rdata_a,
  output logic [DATAWIDTH-1:0] rdata_b,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [DATAWIDTH-1:0] wdata
);

  logic [DATAWIDTH-1:0] regs [REGCOUNT];

  // NOTE: the whole array is cleared on reset, so this stays a flop array;
  // dropping that reset would let synthesis map it to RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGCOUNT; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0)             ? '0    :
                   (we && raddr_a == waddr)      ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0)             ? '0    :
                   (we && raddr_b == waddr)      ? wdata : regs[raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID latch, operand read, load-use interlock, flush/halt
// handling and the registered ID/EX entry.
module instruction_decode
  import mips_pkg::Instruct;
  import mips_pkg::opcode_t;
  import mips_pkg::decode_t;
  import mips_pkg::decode_op;
#(
  parameter int ADDRESSWIDTH = mips_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = 32,
  parameter int REGCOUNT     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] if_pc,
  input  Instruct                 if_instr,
  input  logic                    if_valid,
  output logic                    stall,
  input  logic                    flush,
  input  logic                    wb_we,
  input  logic [4:0]              wb_addr,
  input  logic [DATAWIDTH-1:0]    wb_data,
  output logic                    id_valid,
  output logic [ADDRESSWIDTH-1:0] id_pc,
  output opcode_t                 id_op,
  output logic [4:0]              id_rs_idx,
  output logic [4:0]              id_rt_idx,
  output logic [4:0]              id_dest_idx,
  output logic                    id_dest_we,
  output logic [DATAWIDTH-1:0]    id_rs_val,
  output logic [DATAWIDTH-1:0]    id_rt_val,
  output logic [DATAWIDTH-1:0]    id_imm,
  output logic                    id_is_load,
  output logic                    id_is_store,
  output logic                    id_is_branch,
  output logic                    halted,
  output logic                    illegal
);

  logic                    ifid_valid;
  logic [ADDRESSWIDTH-1:0] ifid_pc;
  Instruct                 ifid_instr;

  decode_t                 dec;
  logic [4:0]              dest_idx;
  logic                    dest_we;
  logic                    load_use;
  logic [DATAWIDTH-1:0]    rs_val;
  logic [DATAWIDTH-1:0]    rt_val;
  logic [DATAWIDTH-1:0]    imm_ext;

  assign dec      = decode_op(ifid_instr.opcode);
  assign dest_idx = !dec.has_dest  ? 5'd0 :
                    dec.dest_is_rd ? ifid_instr.low.r.rd : ifid_instr.rt;
  assign dest_we  = dec.has_dest && (dest_idx != 5'd0);
  assign imm_ext  = {{(DATAWIDTH-16){ifid_instr.low.imm16[15]}}, ifid_instr.low.imm16};

  // Only sources the IF/ID instruction really reads can create a hazard.
  assign load_use = ifid_valid && id_valid && id_is_load && id_dest_we &&
                    ((dec.reads_rs && ifid_instr.rs == id_dest_idx) ||
                     (dec.reads_rt && ifid_instr.rt == id_dest_idx));

  assign stall = halted || load_use;

  register_file #(
    .DATAWIDTH (DATAWIDTH),
    .REGCOUNT  (REGCOUNT)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ifid_instr.rs),
    .raddr_b (ifid_instr.rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid <= if_valid;
      if (if_valid) begin
        ifid_pc    <= if_pc;
        ifid_instr <= if_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_op        <= mips_pkg::ADD;
      id_rs_idx    <= '0;
      id_rt_idx    <= '0;
      id_dest_idx  <= '0;
      id_dest_we   <= 1'b0;
      id_rs_val    <= '0;
      id_rt_val    <= '0;
      id_imm       <= '0;
      id_is_load   <= 1'b0;
      id_is_store  <= 1'b0;
      id_is_branch <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      // NOTE: defaults first, then the issue path overrides them; with
      // non-blocking assignments the last write in the block wins.
      id_valid <= 1'b0;
      illegal  <= 1'b0;
      if (!flush && !halted && !load_use && ifid_valid) begin
        if (dec.legal) begin
          id_valid     <= 1'b1;
          id_pc        <= ifid_pc;
          id_op        <= opcode_t'(ifid_instr.opcode);
          id_rs_idx    <= ifid_instr.rs;
          id_rt_idx    <= ifid_instr.rt;
          id_dest_idx  <= dest_idx;
          id_dest_we   <= dest_we;
          id_rs_val    <= rs_val;
          id_rt_val    <= rt_val;
          id_imm       <= imm_ext;
          id_is_load   <= dec.is_load;
          id_is_store  <= dec.is_store;
          id_is_branch <= dec.is_branch;
          if (dec.is_halt) halted <= 1'b1;
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule
